// File: rtl/papu_pkg.sv
// Shared tables, types and helpers for the pulse/noise tone generator.
package papu_pkg;

    // Duty waveforms; the leftmost bit is step 0.
    localparam logic [7:0] DUTY_TABLE [4] = '{
        8'b0100_0000,
        8'b0110_0000,
        8'b0111_1000,
        8'b1001_1111
    };

    // Noise timer periods in clk cycles, indexed by noise_cfg[3:0].
    localparam logic [11:0] NOISE_PERIOD [16] = '{
        12'd4,   12'd8,   12'd16,  12'd32,
        12'd64,  12'd96,  12'd128, 12'd160,
        12'd202, 12'd254, 12'd380, 12'd508,
        12'd762, 12'd1016, 12'd2034, 12'd4068
    };

    localparam logic [14:0] LFSR_SEED = 15'h0001;

    // Envelope unit state: pending start flag, divider and decay level.
    typedef struct packed {
        logic       start;
        logic [3:0] div;
        logic [3:0] decay;
    } env_t;

    // One LFSR shift; short mode taps bit 6 instead of bit 1.
    function automatic logic [14:0] lfsr_step(input logic [14:0] lfsr, input logic mode);
        logic fb;
        fb = lfsr[0] ^ (mode ? lfsr[6] : lfsr[1]);
        return {fb, lfsr[14:1]};
    endfunction

    // Next envelope state. A restart only arms the start flag; the envelope
    // is not clocked in that cycle even if a quarter-frame tick coincides.
    function automatic env_t env_step(input env_t cur, input logic tick, input logic restart,
                                      input logic [3:0] period, input logic loop);
        env_t nxt;
        nxt = cur;
        if (restart) begin
            nxt.start = 1'b1;
        end else if (tick) begin
            if (cur.start) begin
                nxt.start = 1'b0;
                nxt.decay = 4'd15;
                nxt.div   = period;
            end else if (cur.div == 4'd0) begin
                nxt.div = period;
                if (cur.decay != 4'd0) begin
                    nxt.decay = cur.decay - 4'd1;
                end else if (loop) begin
                    nxt.decay = 4'd15;
                end
            end else begin
                nxt.div = cur.div - 4'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/papu_divider.sv
// Modulo-N clock divider producing a registered one-cycle tick every N clocks.
module papu_divider #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;

    // Count 0..N-1 and flag the wrap so the tick lands N cycles after reset.
    always_comb begin
        cnt_d  = cnt_q + W'(1);
        tick_d = 1'b0;
        if (cnt_q == W'(N - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/papu_pulse_noise.sv
// Pulse (square) and noise tone generator with per-channel envelopes.
module papu_pulse_noise #(
    parameter int FRAME_DIV = 29834,
    parameter int PULSE_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sq_ctrl,
    input  logic [10:0] sq_period,
    input  logic        sq_restart,
    input  logic [7:0]  noise_ctrl,
    input  logic [7:0]  noise_cfg,
    input  logic        noise_restart,
    output logic [3:0]  sq_out,
    output logic [3:0]  noise_out,
    output logic        frame_tick
);
    import papu_pkg::*;

    logic        pulse_tick;
    logic [10:0] timer_q, timer_d;
    logic [2:0]  step_q, step_d;
    logic [11:0] ntimer_q, ntimer_d;
    logic [14:0] lfsr_q, lfsr_d;
    env_t        sq_env_q, sq_env_d;
    env_t        noise_env_q, noise_env_d;
    logic [3:0]  sq_vol, noise_vol;
    logic        duty_bit;

    // Noise length/loop bits above the loop flag and cfg bits 6:4 are not used here.
    logic unused_bits;
    assign unused_bits = ^{noise_ctrl[7:6], noise_cfg[6:4]};

    papu_divider #(.N(FRAME_DIV)) u_frame_div (
        .clk  (clk),
        .rst  (rst),
        .tick (frame_tick)
    );

    papu_divider #(.N(PULSE_DIV)) u_pulse_div (
        .clk  (clk),
        .rst  (rst),
        .tick (pulse_tick)
    );

    // Pulse timer: reload and advance the duty step on underflow; restart rewinds the step only.
    always_comb begin
        timer_d = timer_q;
        step_d  = step_q;
        if (pulse_tick) begin
            if (timer_q == 11'd0) begin
                timer_d = sq_period;
                step_d  = step_q + 3'd1;
            end else begin
                timer_d = timer_q - 11'd1;
            end
        end
        if (sq_restart) begin
            step_d = 3'd0;
        end
    end

    // Noise timer runs every clk and shifts the LFSR each time it expires.
    always_comb begin
        ntimer_d = ntimer_q - 12'd1;
        lfsr_d   = lfsr_q;
        if (ntimer_q == 12'd0) begin
            ntimer_d = NOISE_PERIOD[noise_cfg[3:0]] - 12'd1;
            lfsr_d   = lfsr_step(lfsr_q, noise_cfg[7]);
        end
    end

    // Both envelopes advance on the shared quarter-frame tick.
    always_comb begin
        sq_env_d    = env_step(sq_env_q, frame_tick, sq_restart, sq_ctrl[3:0], sq_ctrl[5]);
        noise_env_d = env_step(noise_env_q, frame_tick, noise_restart, noise_ctrl[3:0], noise_ctrl[5]);
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q     <= '0;
            step_q      <= '0;
            ntimer_q    <= '0;
            lfsr_q      <= LFSR_SEED;
            sq_env_q    <= '0;
            noise_env_q <= '0;
        end else begin
            timer_q     <= timer_d;
            step_q      <= step_d;
            ntimer_q    <= ntimer_d;
            lfsr_q      <= lfsr_d;
            sq_env_q    <= sq_env_d;
            noise_env_q <= noise_env_d;
        end
    end

    // Output mixing; short pulse periods mute, and both channels stay silent while reset is held.
    always_comb begin
        sq_vol    = sq_ctrl[4] ? sq_ctrl[3:0] : sq_env_q.decay;
        noise_vol = noise_ctrl[4] ? noise_ctrl[3:0] : noise_env_q.decay;
        duty_bit  = DUTY_TABLE[sq_ctrl[7:6]][3'd7 - step_q];
        sq_out    = 4'd0;
        noise_out = 4'd0;
        if (!rst && duty_bit && (sq_period >= 11'd8)) begin
            sq_out = sq_vol;
        end
        if (!rst && !lfsr_q[0]) begin
            noise_out = noise_vol;
        end
    end

endmodule

// File: tb/tb_papu_pulse_noise.sv
// Scoreboard bench for papu_pulse_noise with FRAME_DIV=4, PULSE_DIV=2.
module tb_papu_pulse_noise;

  localparam int FRAME_DIV = 4;
  localparam int PULSE_DIV = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sq_ctrl = '0;
  logic [10:0] sq_period = '0;
  logic        sq_restart = 1'b0;
  logic [7:0]  noise_ctrl = '0;
  logic [7:0]  noise_cfg = '0;
  logic        noise_restart = 1'b0;
  logic [3:0]  sq_out;
  logic [3:0]  noise_out;
  logic        frame_tick;

  papu_pulse_noise #(.FRAME_DIV(FRAME_DIV), .PULSE_DIV(PULSE_DIV)) dut (
    .clk           (clk),
    .rst           (rst),
    .sq_ctrl       (sq_ctrl),
    .sq_period     (sq_period),
    .sq_restart    (sq_restart),
    .noise_ctrl    (noise_ctrl),
    .noise_cfg     (noise_cfg),
    .noise_restart (noise_restart),
    .sq_out        (sq_out),
    .noise_out     (noise_out),
    .frame_tick    (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic [3:0]  val;
    logic [15:0] id;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_test = 0;

  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [3:0] act;
    string      nm;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        2'd0:    begin act = sq_out;               nm = "sq_out";     end
        2'd1:    begin act = noise_out;            nm = "noise_out";  end
        default: begin act = {3'b000, frame_tick}; nm = "frame_tick"; end
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL t%0d %s k=%0d: got %0d, expected %0d",
                 e.id / 1000, nm, e.id % 1000, act, e.val);
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    errors++;
    $display("FAIL timeout: simulation did not finish within the allowed wait");
    $finish;
  end

  task automatic push(input int sel, input logic [3:0] v, input int k);
    exp_t e;
    e.sel = 2'(sel);
    e.val = v;
    e.id  = 16'(cur_test * 1000 + k);
    sb_q.push_back(e);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sq_ctrl       = 8'($urandom);
      sq_period     = 11'($urandom);
      sq_restart    = 1'($urandom);
      noise_ctrl    = 8'($urandom);
      noise_cfg     = 8'($urandom);
      noise_restart = 1'($urandom);
      #1;
      checks++;
      if (sq_out !== 4'd0 || noise_out !== 4'd0 || frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset state t%0d i=%0d: sq_out=%0d noise_out=%0d frame_tick=%0b",
                 cur_test, i, sq_out, noise_out, frame_tick);
      end
      push(0, 4'd0, 900 + i);
      push(1, 4'd0, 900 + i);
      push(2, 4'd0, 900 + i);
      next_edge();
    end
    sq_ctrl       = '0;
    sq_period     = '0;
    sq_restart    = 1'b0;
    noise_ctrl    = '0;
    noise_cfg     = '0;
    noise_restart = 1'b0;
    rst           = 1'b0;
  endtask

  function automatic logic [3:0] env_exp(input int k, input bit loop);
    int j;
    if (k < 5) return 4'd0;
    j = (k - 5) / 8;
    if (loop) return 4'(15 - (j % 16));
    return (j >= 15) ? 4'd0 : 4'(15 - j);
  endfunction

  function automatic logic [14:0] lfsr_model(input logic [14:0] l, input bit mode);
    logic fb;
    fb = l[0] ^ (mode ? l[6] : l[1]);
    return {fb, l[14:1]};
  endfunction

  task automatic run_noise(input logic [7:0] cfg, input logic [7:0] ctrl, input bit env,
                           input int n, input int interval);
    logic [14:0] l;
    logic [3:0]  vol;
    l = 15'h0001;
    cur_test++;
    reset_dut();
    noise_cfg  = cfg;
    noise_ctrl = ctrl;
    for (int k = 0; k <= n; k++) begin
      if (k >= 1 && ((k - 1) % interval) == 0) l = lfsr_model(l, cfg[7]);
      vol = env ? env_exp(k, ctrl[5]) : ctrl[3:0];
      push(1, l[0] ? 4'd0 : vol, k);
      if (env) noise_restart = (k == 1);
      next_edge();
    end
    noise_restart = 1'b0;
  endtask

  function automatic logic [3:0] simul_exp(input int k);
    if (k < 5)  return 4'd0;
    if (k < 13) return 4'd15;
    if (k < 21) return 4'd14;
    if (k < 33) return 4'd13;
    if (k < 41) return 4'd15;
    if (k < 49) return 4'd14;
    return 4'd13;
  endfunction

  initial begin
    next_edge();

    cur_test = 1;
    reset_dut();
    for (int k = 0; k <= 13; k++) begin
      push(2, (k != 0 && (k % 4) == 0) ? 4'd1 : 4'd0, k);
      next_edge();
    end

    cur_test = 2;
    reset_dut();
    sq_ctrl   = 8'h9F;
    sq_period = 11'd8;
    for (int k = 0; k <= 170; k++) begin
      push(0, (k == 3 || (k >= 21 && k <= 92) || k >= 165) ? 4'd15 : 4'd0, k);
      sq_restart = (k == 3);
      next_edge();
    end
    sq_restart = 1'b0;

    cur_test = 3;
    reset_dut();
    sq_ctrl   = 8'hDF;
    sq_period = 11'd7;
    for (int k = 0; k <= 140; k++) begin
      push(0, 4'd0, k);
      next_edge();
    end

    cur_test = 3;
    run_noise(8'h00, 8'h1A, 1'b0, 200, 4);
    run_noise(8'h80, 8'h1A, 1'b0, 200, 4);
    run_noise(8'h02, 8'h1A, 1'b0, 320, 16);
    run_noise(8'h00, 8'h21, 1'b1, 300, 4);

    for (int lp = 0; lp < 2; lp++) begin
      cur_test++;
      reset_dut();
      sq_ctrl   = (lp != 0) ? 8'hA1 : 8'h81;
      sq_period = 11'd2047;
      for (int k = 0; k <= (lp != 0 ? 300 : 200); k++) begin
        push(0, env_exp(k, lp != 0), k);
        sq_restart = (k == 1);
        next_edge();
      end
      sq_restart = 1'b0;
    end

    cur_test++;
    reset_dut();
    sq_ctrl   = 8'hC1;
    sq_period = 11'd2047;
    for (int k = 0; k <= 50; k++) begin
      push(0, simul_exp(k), k);
      if (k == 28) push(2, 4'd1, k);
      sq_restart = (k == 3 || k == 28);
      next_edge();
    end
    sq_restart = 1'b0;

    next_edge();
    next_edge();
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations never checked", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
